// File: rtl/sbox_feed_pkg.sv
// Shared types and constants for the masked S-box input feeder.
// Optional randomness refresh is enabled by SBOX_FEED_REFRESH_EN.
package sbox_feed_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam int NSHARE = 3;
   localparam logic [7:0] MAP_ZERO = 8'h00;

   localparam logic [31:0] TV_ONE     = 32'h0000_0001;
   localparam logic [7:0]  TV_S0      = 8'h5A;
   localparam logic [7:0]  TV_S1      = 8'h5B;
   localparam logic [7:0]  TV_S2      = 8'h00;
   localparam logic [7:0]  TV_MAP_ONE = 8'hFF;

endpackage

// File: rtl/sbox_feed_seq_affine_input.sv
// Input linear map of the S-box: bit i of y is the XOR of a[i:0].
// The map is linear over GF(2), so it applies share-wise.
module affine_input
   import sbox_feed_pkg::*;
(
   input  logic [7:0] a,
   output logic [7:0] y
);

   logic [7:0] acc;
   logic       p;

   always_comb begin
      acc = '0;
      p   = 1'b0;
      for (int i = 0; i < 8; i++) begin
         p      = p ^ a[i];
         acc[i] = p;
      end
   end

   // constant term is zero, so masking needs no per-share correction
   assign y = acc ^ MAP_ZERO;

endmodule

// File: rtl/sbox_feed_seq.sv
// Serialises a 3-share word into mapped bytes for the S-box pipeline.
// Define SBOX_FEED_REFRESH_EN to add per-byte mask refresh from rnd.
module sbox_feed_seq
   import sbox_feed_pkg::*;
#(
   parameter  int NBYTE = 4,
   localparam int IW    = (NBYTE > 1) ? $clog2(NBYTE) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*NBYTE-1:0] in_s0,
   input  logic [8*NBYTE-1:0] in_s1,
   input  logic [8*NBYTE-1:0] in_s2,
`ifdef SBOX_FEED_REFRESH_EN
   input  logic [15:0]        rnd,
`endif
   input  logic               out_stall,
   output logic               out_valid,
   output logic [7:0]         out_s0,
   output logic [7:0]         out_s1,
   output logic [7:0]         out_s2,
   output logic [IW-1:0]      out_idx,
   output logic               out_last
);

   state_t             state;
   logic [8*NBYTE-1:0] w0, w1, w2;
   logic               take, adv;
   logic [IW-1:0]      nidx;
   logic [IW+2:0]      bsel;
   logic [8*NBYTE-1:0] src0, src1, src2;
   logic [7:0]         b0, b1, b2;
   logic [7:0]         m0, m1, m2;
   logic [7:0]         r0, r1, r2;

   assign in_ready = (state == IDLE)
                   | ((state == SEND) & out_last & ~out_stall);

   assign take = in_valid & in_ready;
   assign adv  = (state == SEND) & ~out_stall;
   assign nidx = take ? '0 : out_idx + IW'(1);
   assign bsel = {nidx, 3'b000};

   // byte 0 comes straight from the inputs on the capture edge
   assign src0 = take ? in_s0 : w0;
   assign src1 = take ? in_s1 : w1;
   assign src2 = take ? in_s2 : w2;

   assign b0 = src0[bsel +: 8];
   assign b1 = src1[bsel +: 8];
   assign b2 = src2[bsel +: 8];

   affine_input u_aff0 (.a(b0), .y(m0));
   affine_input u_aff1 (.a(b1), .y(m1));
   affine_input u_aff2 (.a(b2), .y(m2));

`ifdef SBOX_FEED_REFRESH_EN
   assign r0 = m0 ^ rnd[7:0] ^ rnd[15:8];
   assign r1 = m1 ^ rnd[7:0];
   assign r2 = m2 ^ rnd[15:8];
`else
   assign r0 = m0;
   assign r1 = m1;
   assign r2 = m2;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_idx   <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_s0    <= '0;
         out_s1    <= '0;
         out_s2    <= '0;
         w0        <= '0;
         w1        <= '0;
         w2        <= '0;
      end else begin
         if (take) begin
            w0 <= in_s0;
            w1 <= in_s1;
            w2 <= in_s2;
         end
         if (take | (adv & ~out_last)) begin
            state     <= SEND;
            out_idx   <= nidx;
            out_valid <= 1'b1;
            out_last  <= (nidx == IW'(NBYTE - 1));
            out_s0    <= r0;
            out_s1    <= r1;
            out_s2    <= r2;
         end else if (adv & out_last) begin
            state     <= IDLE;
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sbox_feed_seq.sv
// Directed and randomized checks for sbox_feed_seq (NBYTE=4).
// Honours SBOX_FEED_REFRESH_EN when the design is built with it.
module tb_sbox_feed_seq;
   import sbox_feed_pkg::*;

   localparam int NB = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_s0, in_s1, in_s2;
   logic        out_stall;
   logic        out_valid;
   logic [7:0]  out_s0, out_s1, out_s2;
   logic [1:0]  out_idx;
   logic        out_last;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

`ifdef SBOX_FEED_REFRESH_EN
   logic [15:0] rnd = 16'h0;
   always @(negedge clk) rnd = 16'($urandom);
`endif

   sbox_feed_seq #(.NBYTE(NB)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_s0     (in_s0),
      .in_s1     (in_s1),
      .in_s2     (in_s2),
`ifdef SBOX_FEED_REFRESH_EN
      .rnd       (rnd),
`endif
      .out_stall (out_stall),
      .out_valid (out_valid),
      .out_s0    (out_s0),
      .out_s1    (out_s1),
      .out_s2    (out_s2),
      .out_idx   (out_idx),
      .out_last  (out_last)
   );

   typedef struct {
      string       name;
      logic [31:0] s0, s1, s2;
      logic [31:0] e0, e1, e2;
   } vec_t;

   vec_t tv[4];

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   function automatic logic [7:0] byte_of(input logic [31:0] w,
                                          input int b);
      return w[8*b +: 8];
   endfunction

   // reference map: y[i] = parity of x[i:0]
   function automatic logic [7:0] ref_map(input logic [7:0] x);
      logic [7:0] y;
      logic [7:0] ones;
      ones = 8'hFF;
      for (int i = 0; i < 8; i++) y[i] = ^(x & (ones >> (7 - i)));
      return y;
   endfunction

   task automatic show(input vec_t v, input int b);
      logic [7:0] ex;
      ex = byte_of(v.e0, b) ^ byte_of(v.e1, b) ^ byte_of(v.e2, b);
      chk($sformatf("%s b%0d valid", v.name, b), 32'(out_valid), 1);
      chk($sformatf("%s b%0d idx", v.name, b), 32'(out_idx), b);
      chk($sformatf("%s b%0d last", v.name, b), 32'(out_last),
          (b == NB - 1) ? 1 : 0);
      chk($sformatf("%s b%0d xor", v.name, b),
          32'(out_s0 ^ out_s1 ^ out_s2), 32'(ex));
`ifndef SBOX_FEED_REFRESH_EN
      chk($sformatf("%s b%0d s0", v.name, b), 32'(out_s0),
          32'(byte_of(v.e0, b)));
      chk($sformatf("%s b%0d s1", v.name, b), 32'(out_s1),
          32'(byte_of(v.e1, b)));
      chk($sformatf("%s b%0d s2", v.name, b), 32'(out_s2),
          32'(byte_of(v.e2, b)));
`endif
   endtask

   task automatic put(input vec_t v);
      in_s0    = v.s0;
      in_s1    = v.s1;
      in_s2    = v.s2;
      in_valid = 1'b1;
   endtask

   task automatic apply_vec(input vec_t v);
      @(negedge clk);
      put(v);
      #1 chk({v.name, " ready"}, 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      for (int b = 0; b < NB; b++) begin
         show(v, b);
         @(negedge clk);
      end
      chk({v.name, " idle"}, 32'(out_valid), 0);
   endtask

   task automatic run_b2b(input vec_t a, input vec_t b);
      vec_t v;
      @(negedge clk);
      put(a);
      @(negedge clk);
      in_s0 = 32'hDEAD_BEEF;
      in_s1 = 32'h1234_5678;
      in_s2 = 32'hCAFE_F00D;
      for (int k = 0; k < 2 * NB; k++) begin
         v = (k < NB) ? a : b;
         show(v, k % NB);
         chk($sformatf("b2b k%0d ready", k), 32'(in_ready),
             ((k % NB) == NB - 1) ? 1 : 0);
         if (k == NB - 1) put(b);
         if (k == NB) in_s0 = 32'hFFFF_FFFF;
         if (k == 2 * NB - 1) in_valid = 1'b0;
         @(negedge clk);
      end
      chk("b2b idle", 32'(out_valid), 0);
   endtask

   task automatic run_stall(input vec_t v);
      @(negedge clk);
      put(v);
      @(negedge clk);
      in_valid = 1'b0;
      show(v, 0);
      @(negedge clk);
      show(v, 1);
      out_stall = 1'b1;
      #1 chk("stall ready", 32'(in_ready), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         show(v, 1);
         if (i == 2) out_stall = 1'b0;
      end
      @(negedge clk);
      show(v, 2);
      @(negedge clk);
      show(v, 3);
      @(negedge clk);
      chk("stall idle", 32'(out_valid), 0);
   endtask

   task automatic run_reset(input vec_t v);
      @(negedge clk);
      put(v);
      @(negedge clk);
      in_valid = 1'b0;
      show(v, 0);
      @(negedge clk);
      show(v, 1);
      @(negedge clk);
      show(v, 2);
      rst = 1'b1;
      @(negedge clk);
      chk("rst valid", 32'(out_valid), 0);
      chk("rst s0", 32'(out_s0), 0);
      chk("rst s1", 32'(out_s1), 0);
      chk("rst s2", 32'(out_s2), 0);
      chk("rst idx", 32'(out_idx), 0);
      chk("rst last", 32'(out_last), 0);
      rst = 1'b0;
      #1 chk("rst ready", 32'(in_ready), 1);
   endtask

   task automatic run_random(input int nwords);
      logic [7:0]  q[$];
      logic [31:0] a, b, c, x;
      logic        pv, ps;
      logic [7:0]  e;
      int          sent, err, cyc;
      pv = 1'b0;
      ps = 1'b0;
      sent = 0;
      err = 0;
      cyc = 0;
      while ((sent < nwords || q.size() != 0 || out_valid)
             && cyc < 80000) begin
         @(negedge clk);
         cyc++;
         if (out_valid && (!pv || !ps)) begin
            if (q.size() == 0) err++;
            else begin
               e = q.pop_front();
               if ((out_s0 ^ out_s1 ^ out_s2) !== e) err++;
            end
         end
         pv = out_valid;
         out_stall = ($urandom_range(0, 3) == 0);
         ps = out_stall;
         #1;
         if (sent < nwords) begin
            if (in_ready) begin
               a = $urandom;
               b = $urandom;
               c = $urandom;
               if (sent % 97 == 0) c = a ^ b;
               in_s0 = a;
               in_s1 = b;
               in_s2 = c;
               x = a ^ b ^ c;
               for (int i = 0; i < NB; i++) q.push_back(ref_map(x[8*i +: 8]));
               sent++;
            end
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
      out_stall = 1'b0;
      in_valid = 1'b0;
      chk("rand xor errors", 32'(err), 0);
      chk("rand words sent", 32'(sent), 32'(nwords));
      chk("rand queue empty", 32'(q.size()), 0);
      chk("rand timeout", 32'(cyc >= 80000), 0);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tv[0] = '{"one", TV_ONE, 32'h0, 32'h0,
                32'h0000_00FF, 32'h0, 32'h0};
      tv[1] = '{"split", {24'h0, TV_S0}, {24'h0, TV_S1}, {24'h0, TV_S2},
                32'h0000_0036, 32'h0000_00C9, 32'h0};
      tv[2] = '{"mixed", 32'h8010_0302, 32'hFF00_0000, 32'h0000_0001,
                32'h80F0_01FE, 32'h5500_0000, 32'h0000_00FF};
      tv[3] = '{"zero", 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

      rst = 1'b1;
      in_valid = 1'b0;
      in_s0 = '0;
      in_s1 = '0;
      in_s2 = '0;
      out_stall = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset valid", 32'(out_valid), 0);
      chk("reset last", 32'(out_last), 0);
      chk("reset s0", 32'(out_s0), 0);
      chk("reset idx", 32'(out_idx), 0);
      rst = 1'b0;
      #1 chk("reset ready", 32'(in_ready), 1);

      chk("split map", 32'(byte_of(tv[1].e0, 0) ^ byte_of(tv[1].e1, 0)),
          32'(TV_MAP_ONE));

      for (int i = 0; i < 4; i++) apply_vec(tv[i]);

      out_stall = 1'b1;
      #1 chk("idle stall ready", 32'(in_ready), 1);
      @(negedge clk);
      chk("idle stall valid", 32'(out_valid), 0);
      out_stall = 1'b0;

      run_b2b(tv[2], tv[1]);
      run_stall(tv[2]);
      run_reset(tv[2]);
      apply_vec(tv[0]);
      run_random(10000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
